// File: rtl/alarm_clock_pkg.sv
// Shared types and constants for the alarm_clock block: BCD digit and
// 7-segment types, segment encodings and the time-of-day limits.
package alarm_clock_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg7_t;

  // Active-high segments, bit order {g,f,e,d,c,b,a}
  localparam seg7_t SEG_0     = 7'h3F;
  localparam seg7_t SEG_1     = 7'h06;
  localparam seg7_t SEG_2     = 7'h5B;
  localparam seg7_t SEG_3     = 7'h4F;
  localparam seg7_t SEG_4     = 7'h66;
  localparam seg7_t SEG_5     = 7'h6D;
  localparam seg7_t SEG_6     = 7'h7D;
  localparam seg7_t SEG_7     = 7'h07;
  localparam seg7_t SEG_8     = 7'h7F;
  localparam seg7_t SEG_9     = 7'h6F;
  localparam seg7_t SEG_BLANK = 7'h00;

  localparam int   HOURS_PER_DAY = 24;
  localparam bcd_t MIN_TENS_MAX  = 4'd5;
  localparam bcd_t DIGIT_MAX     = 4'd9;

  // Last hour of the day split into BCD digits (23 -> 2,3)
  localparam bcd_t HR_HI_LAST = bcd_t'((HOURS_PER_DAY - 1) / 10);
  localparam bcd_t HR_LO_LAST = bcd_t'((HOURS_PER_DAY - 1) % 10);

  // Increment a BCD digit; callers handle the wrap themselves
  function automatic bcd_t bcd_inc(input bcd_t d);
    return d + 4'd1;
  endfunction

endpackage

// File: rtl/alarm_clock_seg7_decoder.sv
// seg7_decoder: purely combinational BCD digit to 7-segment decode.
// Values 10..15 cannot occur in the clock and show a dark digit.
module seg7_decoder
  import alarm_clock_pkg::*;
(
  input  bcd_t  bcd,
  output seg7_t seg
);

  // Lookup of the segment pattern for one digit
  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/alarm_clock.sv
// alarm_clock: 24-hour HH:MM wall clock driving four 7-segment digits.
// A prescaler turns the system clock into second ticks, a seconds counter
// turns those into minute ticks, and a BCD cascade keeps HH:MM.
// Optional feature: define ALARM_EN to add the registered `alarm` output,
// high for the whole minute HH:MM == ALARM_HOUR:ALARM_MINUTE.
module alarm_clock
  import alarm_clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 125_000_000,
  parameter int SEC_PER_MIN   = 60,
  parameter int ALARM_HOUR    = 7,
  parameter int ALARM_MINUTE  = 0
) (
  input  logic  clock,
  input  logic  reset,
  output seg7_t display_minute_LSB,
  output seg7_t display_minute_MSB,
  output seg7_t display_hour_LSB,
  output seg7_t display_hour_MSB
`ifdef ALARM_EN
  ,
  output logic  alarm
`endif
);

  localparam int PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int SEC_W   = (SEC_PER_MIN > 1) ? $clog2(SEC_PER_MIN) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
  localparam logic [SEC_W-1:0]   SEC_LAST   = SEC_W'(SEC_PER_MIN - 1);

  // Catch impossible configurations when the design is elaborated
  if (TICKS_PER_SEC < 1 || SEC_PER_MIN < 1) begin : g_bad_rate
    $error("alarm_clock: TICKS_PER_SEC and SEC_PER_MIN must be >= 1");
  end
  if (ALARM_HOUR < 0 || ALARM_HOUR >= HOURS_PER_DAY ||
      ALARM_MINUTE < 0 || ALARM_MINUTE > 59) begin : g_bad_alarm
    $error("alarm_clock: alarm time outside 00:00..23:59");
  end

  logic [PRESC_W-1:0] presc_reg, presc_next;
  logic [SEC_W-1:0]   sec_reg, sec_next;
  bcd_t               min_lo_reg, min_lo_next;
  bcd_t               min_hi_reg, min_hi_next;
  bcd_t               hr_lo_reg, hr_lo_next;
  bcd_t               hr_hi_reg, hr_hi_next;
  logic               sec_tick;
  logic               min_tick;

  assign sec_tick = (presc_reg == PRESC_LAST);
  assign min_tick = sec_tick && (sec_reg == SEC_LAST);

  // Prescaler and seconds counter: wrap on their last value
  always_comb begin
    presc_next = sec_tick ? '0 : presc_reg + PRESC_W'(1);
    sec_next   = sec_reg;
    if (sec_tick) begin
      sec_next = (sec_reg == SEC_LAST) ? '0 : sec_reg + SEC_W'(1);
    end
  end

  // BCD cascade: every digit that rolls over carries into the next one in
  // the same edge, and 23:59 rolls straight to 00:00
  always_comb begin
    min_lo_next = min_lo_reg;
    min_hi_next = min_hi_reg;
    hr_lo_next  = hr_lo_reg;
    hr_hi_next  = hr_hi_reg;
    if (min_tick) begin
      if (min_lo_reg != DIGIT_MAX) begin
        min_lo_next = bcd_inc(min_lo_reg);
      end else begin
        min_lo_next = '0;
        if (min_hi_reg != MIN_TENS_MAX) begin
          min_hi_next = bcd_inc(min_hi_reg);
        end else begin
          min_hi_next = '0;
          if (hr_hi_reg == HR_HI_LAST && hr_lo_reg == HR_LO_LAST) begin
            hr_hi_next = '0;
            hr_lo_next = '0;
          end else if (hr_lo_reg == DIGIT_MAX) begin
            hr_lo_next = '0;
            hr_hi_next = bcd_inc(hr_hi_reg);
          end else begin
            hr_lo_next = bcd_inc(hr_lo_reg);
          end
        end
      end
    end
  end

  // Timekeeping state; reset forces 00:00 immediately
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      presc_reg  <= '0;
      sec_reg    <= '0;
      min_lo_reg <= '0;
      min_hi_reg <= '0;
      hr_lo_reg  <= '0;
      hr_hi_reg  <= '0;
    end else begin
      presc_reg  <= presc_next;
      sec_reg    <= sec_next;
      min_lo_reg <= min_lo_next;
      min_hi_reg <= min_hi_next;
      hr_lo_reg  <= hr_lo_next;
      hr_hi_reg  <= hr_hi_next;
    end
  end

  // Four identical decoders; index 0 is the minute units digit
  bcd_t  digit_vec [4];
  seg7_t seg_vec   [4];

  assign digit_vec[0] = min_lo_reg;
  assign digit_vec[1] = min_hi_reg;
  assign digit_vec[2] = hr_lo_reg;
  assign digit_vec[3] = hr_hi_reg;

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    seg7_decoder u_dec (
      .bcd (digit_vec[gi]),
      .seg (seg_vec[gi])
    );
  end

  assign display_minute_LSB = seg_vec[0];
  assign display_minute_MSB = seg_vec[1];
  assign display_hour_LSB   = seg_vec[2];
  assign display_hour_MSB   = seg_vec[3];

`ifdef ALARM_EN
  localparam bcd_t AL_HR_HI  = bcd_t'(ALARM_HOUR / 10);
  localparam bcd_t AL_HR_LO  = bcd_t'(ALARM_HOUR % 10);
  localparam bcd_t AL_MIN_HI = bcd_t'(ALARM_MINUTE / 10);
  localparam bcd_t AL_MIN_LO = bcd_t'(ALARM_MINUTE % 10);

  logic alarm_reg;
  logic alarm_next;

  assign alarm_next = (hr_hi_reg == AL_HR_HI) && (hr_lo_reg == AL_HR_LO) &&
                      (min_hi_reg == AL_MIN_HI) && (min_lo_reg == AL_MIN_LO);

  // Registered compare: follows the displayed minute by one cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alarm_reg <= 1'b0;
    end else begin
      alarm_reg <= alarm_next;
    end
  end

  assign alarm = alarm_reg;
`endif

endmodule

// File: tb/tb_alarm_clock.sv
// Bench for alarm_clock with one minute = 6 clocks. The stimulus side keeps
// a count of clock edges since reset release, derives the expected HH:MM
// from it with plain arithmetic and queues the expected displays; a monitor
// on the falling edge pops and compares.
module tb_alarm_clock;

  localparam int TPS = 2;
  localparam int SPM = 3;
  localparam int AH  = 0;
  localparam int AM  = 2;
  localparam int CPM = TPS * SPM;
  localparam int MIN_PER_DAY = 24 * 60;

  logic       clock;
  logic       reset;
  logic [6:0] d_min_lsb, d_min_msb, d_hr_lsb, d_hr_msb;
`ifdef ALARM_EN
  logic       alarm;
`endif

  alarm_clock #(
    .TICKS_PER_SEC (TPS),
    .SEC_PER_MIN   (SPM),
    .ALARM_HOUR    (AH),
    .ALARM_MINUTE  (AM)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .display_minute_LSB (d_min_lsb),
    .display_minute_MSB (d_min_msb),
    .display_hour_LSB   (d_hr_lsb),
    .display_hour_MSB   (d_hr_msb)
`ifdef ALARM_EN
    ,
    .alarm              (alarm)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [27:0] disp;   // {hour tens, hour units, minute tens, minute units}
    logic        alarm;
    int unsigned k;
  } exp_t;

  logic [6:0]  seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  exp_t        sb_q[$];
  int unsigned k;          // rising edges since reset release
  int          checks   = 0;
  int          failures = 0;

  function automatic int minute_of(input int unsigned edges);
    return int'((edges / CPM) % MIN_PER_DAY);
  endfunction

  function automatic logic [27:0] disp_for(input int m);
    int hh, mm;
    hh = m / 60;
    mm = m % 60;
    return {seg_tab[hh / 10], seg_tab[hh % 10], seg_tab[mm / 10], seg_tab[mm % 10]};
  endfunction

  // One clock cycle: optional async assert / release mid-cycle, then queue
  // what the displays must show for the rest of this cycle
  task automatic step(input bit assert_rst, input bit release_rst);
    exp_t e;
    @(posedge clock);
    if (reset) k++;
    #1;
    if (assert_rst) begin
      reset = 1'b0;
      k = 0;
    end
    if (release_rst) reset = 1'b1;
    e.disp  = disp_for(minute_of(k));
    e.alarm = (k >= 1) && (minute_of(k - 1) == AH * 60 + AM);
    e.k     = k;
    sb_q.push_back(e);
  endtask

  // Monitor: compare on the falling edge, away from the active edge
  always @(negedge clock) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      checks++;
      if ({d_hr_msb, d_hr_lsb, d_min_msb, d_min_lsb} !== e.disp) begin
        failures++;
        $display("FAIL display k=%0d reset=%b got=%h required=%h", e.k, reset,
                 {d_hr_msb, d_hr_lsb, d_min_msb, d_min_lsb}, e.disp);
      end
`ifdef ALARM_EN
      checks++;
      if (alarm !== e.alarm) begin
        failures++;
        $display("FAIL alarm k=%0d got=%b required=%b", e.k, alarm, e.alarm);
      end
`endif
    end
  end

  initial begin
    int n;
    k = 0;
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (3) step(0, 0);
    step(0, 1);
    // Run into minute 7, then pull reset between edges
    repeat (7 * CPM + 2) step(0, 0);
    step(1, 0);
    repeat (2) step(0, 0);
    step(0, 1);
    // Random run lengths interrupted by async resets
    for (int s = 0; s < 6; s++) begin
      n = $urandom_range(1, 400);
      repeat (n) step(0, 0);
      step(1, 0);
      n = $urandom_range(0, 2);
      repeat (n) step(0, 0);
      step(0, 1);
    end
    // A full day plus a little: covers 00:59, 09:59 and 23:59 rollovers
    repeat (MIN_PER_DAY * CPM + 30) step(0, 0);
    // Drain the scoreboard within a bounded number of cycles
    for (int w = 0; w < 4 && sb_q.size() > 0; w++) @(negedge clock);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
